wb_stage: RTL
=============

WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 Parameter LOAD_TIMEOUT, default 16: max cycles a load waits for read data before abort.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 reset  in  1  synchronous, active-high; clears all state on the clock edge where it is sampled high.
REQ-004 wb_result  in  32  EX/WB result (ALU/LUI/link value).
REQ-005 wb_alu_to_reg  in  1  instruction in WB writes a register.
REQ-006 wb_mem_to_reg  in  1  instruction in WB is a load.
REQ-007 wb_dest_reg_sel  in  5  destination register index.
REQ-008 wb_read_address  in  2  load byte offset within word.
REQ-009 mem_alu_operation  in  3  load funct3: LB=000, LH=001, LW=010, LBU=100, LHU=101.
REQ-010 dmem_rdata  in  32  data-memory read word.
REQ-011 dmem_rvalid  in  1  dmem_rdata valid this cycle.
REQ-012 stall_read  out  1  high = hold EX/WB register and upstream stages.
REQ-013 rf_we / rf_waddr / rf_wdata  out  1/5/32  registered register-file write port.
REQ-014 load_misaligned  out  1  one-cycle pulse, misaligned load dropped.
REQ-015 load_timeout  out  1  one-cycle pulse, load aborted after LOAD_TIMEOUT cycles.

Function
REQ-016 States: IDLE, LOAD_WAIT; the EX/WB register advances on every edge where stall_read is low.
REQ-017 Non-load (wb_alu_to_reg=1, wb_mem_to_reg=0) in IDLE: next edge rf_we=1, rf_waddr=wb_dest_reg_sel, rf_wdata=wb_result; stall_read=0.
REQ-018 Load in IDLE, aligned, dmem_rvalid=1: no stall; next edge writes extracted data; state stays IDLE.
REQ-019 Load in IDLE, aligned, dmem_rvalid=0: stall_read=1 combinationally; next state LOAD_WAIT; wait counter cleared to 1.
REQ-020 LOAD_WAIT: stall_read=1 while dmem_rvalid=0 and counter<LOAD_TIMEOUT; counter increments each cycle.
REQ-021 LOAD_WAIT, dmem_rvalid=1: stall_read=0 same cycle; next edge writes extracted data; return to IDLE.
REQ-022 LOAD_WAIT, counter==LOAD_TIMEOUT with dmem_rvalid=0: stall_read=0, load_timeout pulses on next edge, no register write, return to IDLE.
REQ-023 dmem_rvalid and timeout in same cycle: data wins, no timeout pulse.
REQ-024 Extraction: byte = rdata[8*off+:8], half = rdata[16*off[1]+:16]; LB/LH sign-extend, LBU/LHU zero-extend, LW whole word; other funct3 values write 0.
REQ-025 Misaligned (LH/LHU off[0]=1, LW off!=0): no stall, no write, load_misaligned pulses next edge; dmem_rvalid ignored.
REQ-026 wb_dest_reg_sel=0: rf_we stays 0 for any instruction.
REQ-027 wb_alu_to_reg=0: no write, no stall, state unaffected.
REQ-028 dmem_rvalid in IDLE without a load: ignored.
REQ-029 Counter width = clog2(LOAD_TIMEOUT)+1; never wraps.

Reset
REQ-030 Reset: state=IDLE, counter=0, rf_we=0, rf_waddr=0, rf_wdata=0, load_misaligned=0, load_timeout=0.
REQ-031 stall_read=0 whenever reset is high.
REQ-032 Reset mid-LOAD_WAIT aborts the load: no write, no timeout pulse, stall released.

Structure
REQ-033 Load funct3 encodings and state enum in shared package riscv_pkg beside existing opcode constants.
REQ-034 One sub-module load_align (offset/funct3 -> extended 32-bit value, misaligned flag), combinational.

Verification
REQ-035 ADD result 0x0000_1234 to x5 -> next edge rf_we=1, rf_waddr=5, rf_wdata=0x0000_1234, stall_read=0.
REQ-036 LB off=3, rdata=0x80AA_BBCC, rvalid same cycle -> rf_wdata=0xFFFF_FF80; LBU same -> 0x0000_0080.
REQ-037 LW, rvalid after 3 cycles -> stall_read high exactly 3 cycles, then write of rdata, state IDLE.
REQ-038 LW, rvalid never, LOAD_TIMEOUT=4 -> stall 4 cycles, load_timeout single pulse, rf_we=0.
REQ-039 LH off=1 -> load_misaligned pulse, rf_we=0, no stall; ADD to x0 -> rf_we=0.
REQ-040 Reset asserted in 2nd LOAD_WAIT cycle -> next edge all outputs 0, IDLE; late rvalid ignored.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RISC-V core definitions: opcodes, load funct3 encodings, WB-stage states
// and the result record produced by the load aligner.
package riscv_pkg;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    localparam logic [0:0] ST_IDLE      = 1'b0;
    localparam logic [0:0] ST_LOAD_WAIT = 1'b1;

    typedef struct packed {
        logic [31:0] data;
        logic        misaligned;
    } load_result_t;

endpackage

// File: rtl/load_align.sv
// Combinational load data aligner: picks the addressed byte/half/word out of the
// memory read word, extends it per funct3 and flags misaligned accesses.
module load_align
    import riscv_pkg::*;
(
    input  logic [31:0]  rdata,
    input  logic [1:0]   offset,
    input  logic [2:0]   funct3,
    output load_result_t result
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        case (offset)
            2'd0:    byte_sel = rdata[7:0];
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            default: byte_sel = rdata[31:24];
        endcase
        half_sel = offset[1] ? rdata[31:16] : rdata[15:0];
    end

    // Unknown funct3 values produce zero data and are never treated as misaligned.
    always_comb begin
        result.data       = 32'h0000_0000;
        result.misaligned = 1'b0;
        case (funct3)
            F3_LB:  result.data = {{24{byte_sel[7]}}, byte_sel};
            F3_LBU: result.data = {24'h00_0000, byte_sel};
            F3_LH: begin
                result.data       = {{16{half_sel[15]}}, half_sel};
                result.misaligned = offset[0];
            end
            F3_LHU: begin
                result.data       = {16'h0000, half_sel};
                result.misaligned = offset[0];
            end
            F3_LW: begin
                result.data       = rdata;
                result.misaligned = (offset != 2'd0);
            end
            default: begin
                result.data       = 32'h0000_0000;
                result.misaligned = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// Write-back stage: drives the register-file write port, and stalls the pipeline
// while a load waits for data memory, aborting it after LOAD_TIMEOUT cycles.
module wb_stage
    import riscv_pkg::*;
#(
    parameter int LOAD_TIMEOUT = 16
)
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] wb_result,
    input  logic        wb_alu_to_reg,
    input  logic        wb_mem_to_reg,
    input  logic [4:0]  wb_dest_reg_sel,
    input  logic [1:0]  wb_read_address,
    input  logic [2:0]  mem_alu_operation,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_rvalid,
    output logic        stall_read,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic        load_misaligned,
    output logic        load_timeout
);

    localparam int            CW          = $clog2(LOAD_TIMEOUT) + 1;
    localparam logic [CW-1:0] TIMEOUT_VAL = CW'(LOAD_TIMEOUT);

    logic [0:0]    state;
    logic [0:0]    state_next;
    logic [CW-1:0] wait_cnt;
    logic [CW-1:0] wait_cnt_next;
    load_result_t  aligned;
    logic          is_load;
    logic          write_en;
    logic          write_ok;
    logic [31:0]   write_data;
    logic          misaligned_hit;
    logic          timeout_hit;

    load_align u_load_align (
        .rdata  (dmem_rdata),
        .offset (wb_read_address),
        .funct3 (mem_alu_operation),
        .result (aligned)
    );

    assign is_load  = wb_alu_to_reg && wb_mem_to_reg;
    assign write_ok = write_en && (wb_dest_reg_sel != 5'd0);

    // In LOAD_WAIT the EX/WB register is frozen, so the held load is still presented.
    always_comb begin
        state_next     = state;
        wait_cnt_next  = wait_cnt;
        stall_read     = 1'b0;
        write_en       = 1'b0;
        write_data     = wb_result;
        misaligned_hit = 1'b0;
        timeout_hit    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (is_load) begin
                    if (aligned.misaligned) begin
                        misaligned_hit = 1'b1;
                    end else if (dmem_rvalid) begin
                        write_en   = 1'b1;
                        write_data = aligned.data;
                    end else begin
                        stall_read    = 1'b1;
                        state_next    = ST_LOAD_WAIT;
                        wait_cnt_next = CW'(1);
                    end
                end else if (wb_alu_to_reg) begin
                    write_en = 1'b1;
                end
            end
            default: begin
                if (dmem_rvalid) begin
                    write_en      = 1'b1;
                    write_data    = aligned.data;
                    state_next    = ST_IDLE;
                    wait_cnt_next = '0;
                end else if (wait_cnt < TIMEOUT_VAL) begin
                    stall_read    = 1'b1;
                    wait_cnt_next = wait_cnt + 1'b1;
                end else begin
                    timeout_hit   = 1'b1;
                    state_next    = ST_IDLE;
                    wait_cnt_next = '0;
                end
            end
        endcase
        if (reset) begin
            stall_read = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= ST_IDLE;
            wait_cnt        <= '0;
            rf_we           <= 1'b0;
            rf_waddr        <= 5'd0;
            rf_wdata        <= 32'h0000_0000;
            load_misaligned <= 1'b0;
            load_timeout    <= 1'b0;
        end else begin
            state           <= state_next;
            wait_cnt        <= wait_cnt_next;
            rf_we           <= write_ok;
            load_misaligned <= misaligned_hit;
            load_timeout    <= timeout_hit;
            if (write_ok) begin
                rf_waddr <= wb_dest_reg_sel;
                rf_wdata <= write_data;
            end
        end
    end

endmodule
